// File: rtl/mem_access_unit.sv
// mem_access_unit: multi-cycle byte/halfword/word memory port for the
// microcoded ARMv4 core. Word-organised little-endian RAM, fixed wait count,
// one-cycle mem_r completion pulse, read data held until the next completed read.
// Optional feature: define MEM_ALIGN_CHECK_EN to flag misaligned halfword/word
// accesses on abort (write suppressed, rdata left unchanged).
module mem_access_unit #(
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              mem_r,
  output logic              busy,
  output logic              abort
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t             state;
  logic [3:0]         cnt;
  logic               lat_we;
  logic [1:0]         lat_size;
  logic [1:0]         lat_lane;
  logic [IDX_W-1:0]   lat_idx;
  logic [31:0]        lat_wdata;
  logic               abort_reg;

  logic [31:0]        mem [DEPTH_WORDS];
  logic [31:0]        ram_q;

  logic               finish;
  logic               misalign;
  logic               commit;
  logic               load;
  logic [3:0]         be;
  logic [31:0]        wd;
  logic [31:0]        rot;
  logic [31:0]        rd_fmt;

  // Address bits above the RAM index wrap around and are deliberately ignored.
  logic               addr_unused;
  assign addr_unused = ^addr[ADDR_W-1:IDX_W+2];

  // Last WAIT cycle with the request still held: the access completes here.
  assign finish = (state == WAIT) && cs && (cnt == 4'd0);

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = ((lat_size == 2'b01) && lat_lane[0]) ||
                    (lat_size[1] && (lat_lane != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign commit = finish && lat_we && !misalign;
  assign load   = finish && !lat_we && !misalign;
  // Without the alignment check abort_reg only ever loads 0.
  assign abort  = abort_reg;

  // Byte-lane enables and lane-replicated write data for the latched request.
  always_comb begin
    be = 4'b1111;
    wd = lat_wdata;
    case (lat_size)
      2'b00: begin
        be = 4'b0001 << lat_lane;
        wd = {4{lat_wdata[7:0]}};
      end
      2'b01: begin
        be = lat_lane[1] ? 4'b1100 : 4'b0011;
        wd = {2{lat_wdata[15:0]}};
      end
      default: begin
        be = 4'b1111;
        wd = lat_wdata;
      end
    endcase
  end

  // Read formatting: rotate right by the byte offset (LDR semantics); the
  // low byte of the rotated word is the addressed byte lane.
  always_comb begin
    rot    = 32'({ram_q, ram_q} >> {lat_lane, 3'b000});
    rd_fmt = rot;
    case (lat_size)
      2'b00:   rd_fmt = {24'b0, rot[7:0]};
      2'b01:   rd_fmt = {16'b0, (lat_lane[1] ? ram_q[31:16] : ram_q[15:0])};
      default: rd_fmt = rot;
    endcase
  end

  // RAM: word fetched when the request is accepted, byte-enabled write on completion.
  always_ff @(posedge clk) begin
    if ((state == IDLE) && cs) begin
      ram_q <= mem[addr[IDX_W+1:2]];
    end
    if (commit) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem[lat_idx][8*i +: 8] <= wd[8*i +: 8];
        end
      end
    end
  end

  // Access sequencer: IDLE -> WAIT (LATENCY cycles) -> DONE -> IDLE, registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      lat_we    <= 1'b0;
      lat_size  <= 2'b00;
      lat_lane  <= 2'b00;
      lat_idx   <= '0;
      lat_wdata <= 32'd0;
      rdata     <= 32'd0;
      mem_r     <= 1'b0;
      busy      <= 1'b0;
      abort_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          mem_r     <= 1'b0;
          abort_reg <= 1'b0;
          if (cs) begin
            lat_we    <= we;
            lat_size  <= size;
            lat_lane  <= addr[1:0];
            lat_idx   <= addr[IDX_W+1:2];
            lat_wdata <= wdata;
            cnt       <= 4'(LATENCY - 1);
            busy      <= 1'b1;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (!cs) begin
            // Sequencer abandoned the microstate: nothing is written or loaded.
            cnt   <= 4'd0;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (cnt == 4'd0) begin
            mem_r     <= 1'b1;
            abort_reg <= misalign;
            if (load) begin
              rdata <= rd_fmt;
            end
            state <= DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          // cs here belongs to the completing microstate; always bubble via IDLE.
          mem_r     <= 1'b0;
          abort_reg <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          mem_r     <= 1'b0;
          abort_reg <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
